// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter
//   Shares one byte-level I2C controller between NUM_REQ requesters.
//   Requests are granted round-robin. The winner's command is latched and
//   presented to the controller, and the completion (read byte, ack status)
//   is returned only to that requester as a one-cycle pulse.
//
// Optional build macro: I2C_ARB_TIMEOUT_EN
//   When defined, a transaction that runs TIMEOUT_CYCLES cycles from issue is
//   forced to complete with rsp_timeout=1 and rsp_ack_error=1. After such a
//   timeout, and in general, no new grant is made while m_busy is still high.
//   When undefined, the arbiter waits for the controller indefinitely and
//   rsp_timeout is tied to 0.
//
// Ports
//   clock, reset                  system clock, asynchronous active-high reset
//   req_valid/rw/addr/wdata       per-requester commands (packed, requester i
//                                 at [i*W +: W])
//   req_ready                     one-hot accept, only in IDLE
//   rsp_valid                     one-hot one-cycle completion pulse
//   rsp_rdata/ack_error/timeout   shared completion fields, qualified by rsp_valid
//   m_rw/slave_addr/tx_data/ready command to the I2C controller
//   m_busy/valid/rx_data/ack_error status from the I2C controller
//   arb_busy                      high whenever a transaction is in flight
//   grant_id                      index of the current or last winner
//
// FSM states
//   state     | meaning
//   IDLE      | waiting for a request; req_ready marks the round-robin winner
//   ISSUE     | m_ready asserted, waiting for the controller to go busy
//   WAIT_DONE | controller busy; capturing read data and ack errors
//   RESPOND   | one-cycle rsp_valid to the winner; update round-robin pointer

module i2c_txn_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 65536,
    localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_ack_error,
    output logic                          rsp_timeout,
    output logic                          m_rw,
    output logic [ADDR_WIDTH-1:0]         m_slave_addr,
    output logic [DATA_WIDTH-1:0]         m_tx_data,
    output logic                          m_ready,
    input  logic                          m_busy,
    input  logic                          m_valid,
    input  logic [DATA_WIDTH-1:0]         m_rx_data,
    input  logic                          m_ack_error,
    output logic                          arb_busy,
    output logic [GW-1:0]                 grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESPOND} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [GW-1:0]           last_grant;
    logic [NUM_REQ-1:0]      win_onehot;
    logic [GW-1:0]           win_idx;
    logic                    any_valid;
    logic                    grant_ok;
    logic                    accept;
    logic                    sel_rw;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    err_flag;
    logic                    expire;

    // Round-robin search starting just above the last winner.
    always_comb begin
        int            t;
        logic [GW-1:0] idx;
        win_onehot = '0;
        win_idx    = '0;
        any_valid  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            t = int'(last_grant) + 1 + k;
            if (t >= NUM_REQ) t = t - NUM_REQ;
            idx = GW'(t);
            if (!any_valid && req_valid[idx]) begin
                any_valid       = 1'b1;
                win_idx         = idx;
                win_onehot[idx] = 1'b1;
            end
        end
    end

    // Only the winner's fields reach the command registers.
    always_comb begin
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_rw    = sel_rw | (req_rw[i] & win_onehot[i]);
            sel_addr  = sel_addr  | (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{win_onehot[i]}});
            sel_wdata = sel_wdata | (req_wdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{win_onehot[i]}});
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic          tout_flag;
    logic          timeout_hit;

    // A timed-out controller may still be busy; hold off the next grant.
    assign grant_ok    = ~m_busy;
    assign timeout_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    // A genuine completion in the same cycle wins over the timeout.
    assign expire      = timeout_hit & ((state == ISSUE) | ((state == WAIT_DONE) & m_busy));
    assign rsp_timeout = (state == RESPOND) & tout_flag;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_cnt    <= '0;
            tout_flag <= 1'b0;
        end else begin
            if (accept) begin
                to_cnt    <= '0;
                tout_flag <= 1'b0;
            end else if ((state == ISSUE) || (state == WAIT_DONE)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (expire) tout_flag <= 1'b1;
        end
    end
`else
    assign grant_ok    = 1'b1;
    assign expire      = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign accept = (state == IDLE) & grant_ok & any_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = ISSUE;
            ISSUE: begin
                if (expire)      state_nxt = RESPOND;
                else if (m_busy) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: if (!m_busy || expire) state_nxt = RESPOND;
            RESPOND:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = '0;
        m_ready       = 1'b0;
        rsp_valid     = '0;
        rsp_ack_error = 1'b0;
        arb_busy      = (state != IDLE);
        case (state)
            IDLE:    if (grant_ok) req_ready = win_onehot;
            ISSUE:   m_ready = ~expire;
            RESPOND: begin
                for (int i = 0; i < NUM_REQ; i++) rsp_valid[i] = (grant_id == GW'(i));
                rsp_ack_error = err_flag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_rw         <= 1'b0;
            m_slave_addr <= '0;
            m_tx_data    <= '0;
            grant_id     <= '0;
            rsp_rdata    <= '0;
            err_flag     <= 1'b0;
            last_grant   <= GW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_rw         <= sel_rw;
                        m_slave_addr <= sel_addr;
                        m_tx_data    <= sel_wdata;
                        grant_id     <= win_idx;
                        rsp_rdata    <= '0;
                        err_flag     <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (m_valid)     rsp_rdata <= m_rx_data;
                    if (m_ack_error) err_flag  <= 1'b1;
                end
                RESPOND: last_grant <= grant_id;
                default: ;
            endcase
            if (expire) err_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Testbench for i2c_txn_arbiter: table-driven transactions with a scripted
// controller model, a response scoreboard, plus reset, fairness and stuck-busy
// sequences.

module tb_i2c_txn_arbiter;

    localparam int N  = 4;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int GW = 2;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 65536;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_rw;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_ack_error;
    logic            rsp_timeout;
    logic            m_rw;
    logic [AW-1:0]   m_slave_addr;
    logic [DW-1:0]   m_tx_data;
    logic            m_ready;
    logic            m_busy;
    logic            m_valid;
    logic [DW-1:0]   m_rx_data;
    logic            m_ack_error;
    logic            arb_busy;
    logic [GW-1:0]   grant_id;

    i2c_txn_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_ack_error(rsp_ack_error), .rsp_timeout(rsp_timeout),
        .m_rw(m_rw), .m_slave_addr(m_slave_addr), .m_tx_data(m_tx_data), .m_ready(m_ready),
        .m_busy(m_busy), .m_valid(m_valid), .m_rx_data(m_rx_data), .m_ack_error(m_ack_error),
        .arb_busy(arb_busy), .grant_id(grant_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0]  onehot;
        logic [DW-1:0] rdata;
        logic          ack;
        logic          tout;
    } exp_t;

    typedef struct {
        logic [N-1:0]  mask;
        int            win;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rx;
        logic          nack;
        logic          nack_at_fall;
        int            busy_len;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[7];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int rr_next(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && rsp_valid != '0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual rsp_valid=%b required none at %0t", rsp_valid, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_rsp_valid", 32'(rsp_valid), 32'(mon_e.onehot));
                chk("sb_rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                chk("sb_rsp_ack_error", 32'(rsp_ack_error), 32'(mon_e.ack));
                chk("sb_rsp_timeout", 32'(rsp_timeout), 32'(mon_e.tout));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic set_fields(input int win, input logic rw, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata);
        for (int i = 0; i < N; i++) begin
            req_rw[i]              = (i == win) ? rw : ~rw;
            req_addr[i*AW +: AW]   = (i == win) ? addr : ~addr;
            req_wdata[i*DW +: DW]  = (i == win) ? wdata : ~wdata;
        end
    endtask

    // Starts and ends at a falling edge with the arbiter in IDLE.
    task automatic run_txn(input vec_t v, input bit hold, output int got_grant);
        exp_t         e;
        logic [N-1:0] oh;
        oh = '0;
        oh[v.win] = 1'b1;
        set_fields(v.win, v.rw, v.addr, v.wdata);
        req_valid = v.mask;
        #1;
        chk("req_ready_idle", 32'(req_ready), 32'(oh));
        e.onehot = oh;
        e.rdata  = v.rw ? v.rx : '0;
        e.ack    = v.nack | v.nack_at_fall;
        e.tout   = 1'b0;
        sb.push_back(e);
        @(negedge clock);
        got_grant = int'(grant_id);
        chk("m_ready_issue", 32'(m_ready), 1);
        chk("grant_id", 32'(grant_id), 32'(v.win));
        chk("m_rw", 32'(m_rw), 32'(v.rw));
        chk("m_slave_addr", 32'(m_slave_addr), 32'(v.addr));
        chk("m_tx_data", 32'(m_tx_data), 32'(v.wdata));
        chk("req_ready_busy", 32'(req_ready), 0);
        chk("arb_busy_issue", 32'(arb_busy), 1);
        if (!hold) req_valid = '0;
        @(negedge clock);
        chk("m_ready_hold", 32'(m_ready), 1);
        chk("m_slave_addr_hold", 32'(m_slave_addr), 32'(v.addr));
        m_busy = 1'b1;
        @(negedge clock);
        chk("m_ready_drop", 32'(m_ready), 0);
        if (v.rw) begin
            m_valid   = 1'b1;
            m_rx_data = v.rx;
        end
        if (v.nack) m_ack_error = 1'b1;
        @(negedge clock);
        m_valid     = 1'b0;
        m_ack_error = 1'b0;
        m_rx_data   = ~v.rx;
        repeat (v.busy_len) @(negedge clock);
        m_busy = 1'b0;
        if (v.nack_at_fall) m_ack_error = 1'b1;
        @(negedge clock);
        m_ack_error = 1'b0;
        chk("rsp_latency", 32'(rsp_valid), 32'(oh));
        @(negedge clock);
        chk("rsp_pulse_end", 32'(rsp_valid), 0);
        chk("arb_idle", 32'(arb_busy), 0);
    endtask

    initial begin
        int   g;
        int   prev;
        int   tb_last;
        int   fair_seen[5];
        vec_t fv;
        exp_t e;

        //          mask     win rw    addr   wdata  rx     nack  at_fall busy_len
        vt[0] = '{4'b0100, 2, 1'b0, 7'h50, 8'hA5, 8'h00, 1'b0, 1'b0, 2};
        vt[1] = '{4'b0010, 1, 1'b1, 7'h1D, 8'h00, 8'h3C, 1'b0, 1'b0, 1};
        vt[2] = '{4'b1000, 3, 1'b0, 7'h22, 8'h11, 8'h00, 1'b1, 1'b0, 3};
        vt[3] = '{4'b1000, 3, 1'b0, 7'h23, 8'h12, 8'h00, 1'b0, 1'b0, 0};
        vt[4] = '{4'b1111, 0, 1'b1, 7'h7F, 8'h00, 8'hFF, 1'b0, 1'b1, 2};
        vt[5] = '{4'b1001, 3, 1'b0, 7'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1};
        vt[6] = '{4'b0110, 1, 1'b1, 7'h41, 8'h00, 8'h81, 1'b0, 1'b0, 0};

        reset       = 1'b1;
        req_valid   = '0;
        req_rw      = '0;
        req_addr    = '0;
        req_wdata   = '0;
        m_busy      = 1'b0;
        m_valid     = 1'b0;
        m_rx_data   = '0;
        m_ack_error = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_m_ready", 32'(m_ready), 0);
        chk("rst_arb_busy", 32'(arb_busy), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_m_slave_addr", 32'(m_slave_addr), 0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 7; i++) run_txn(vt[i], 1'b0, g);

        // Reset in WAIT_DONE abandons the transaction silently.
        set_fields(2, 1'b1, 7'h55, 8'h5A);
        req_valid = 4'b0100;
        @(negedge clock);
        req_valid = '0;
        m_busy    = 1'b1;
        @(negedge clock);
        chk("pre_rst_arb_busy", 32'(arb_busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_m_ready", 32'(m_ready), 0);
        chk("midrst_arb_busy", 32'(arb_busy), 0);
        chk("midrst_grant_id", 32'(grant_id), 0);
        chk("midrst_m_slave_addr", 32'(m_slave_addr), 0);
        chk("midrst_m_tx_data", 32'(m_tx_data), 0);
        chk("midrst_m_rw", 32'(m_rw), 0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_rsp_ack_error", 32'(rsp_ack_error), 0);
        m_busy = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("post_rst_idle", 32'(arb_busy), 0);

        // Fairness: all requesters held high, back-to-back grants.
        tb_last = N - 1;
        prev    = -1;
        for (int k = 0; k < 5; k++) begin
            fv.mask         = 4'b1111;
            fv.win          = rr_next(4'b1111, tb_last);
            fv.rw           = k[0];
            fv.addr         = AW'(7'h10 + k);
            fv.wdata        = DW'(8'hC0 + k);
            fv.rx           = DW'(8'h90 + k);
            fv.nack         = 1'b0;
            fv.nack_at_fall = 1'b0;
            fv.busy_len     = 1;
            run_txn(fv, 1'b1, g);
            fair_seen[k] = g;
            checks++;
            if (g == prev) begin
                failures++;
                $display("FAIL fair_repeat actual=%0d required!=%0d", g, prev);
            end
            prev    = g;
            tb_last = fv.win;
        end
        req_valid = '0;
        chk("fair_seq0", 32'(fair_seen[0]), 0);
        chk("fair_seq4", 32'(fair_seen[4]), 0);

        // Controller stuck busy.
        set_fields(0, 1'b0, 7'h33, 8'h44);
        req_valid = 4'b0001;
        #1;
        chk("stuck_req_ready", 32'(req_ready), 1);
        @(negedge clock);
        req_valid = '0;
        m_busy    = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
        begin
            int n;
            e.onehot = 4'b0001;
            e.rdata  = '0;
            e.ack    = 1'b1;
            e.tout   = 1'b1;
            sb.push_back(e);
            n = 0;
            while (rsp_valid == '0 && n < 300) begin
                @(negedge clock);
                n++;
            end
            chk("timeout_cycles", 32'(n), TO);
            @(negedge clock);
            chk("timeout_m_ready", 32'(m_ready), 0);
            req_valid = 4'b0001;
            #1;
            chk("timeout_grant_blocked", 32'(req_ready), 0);
            m_busy = 1'b0;
            #1;
            chk("timeout_grant_free", 32'(req_ready), 1);
            req_valid = '0;
        end
`else
        repeat (1000) @(negedge clock);
        chk("stuck_arb_busy", 32'(arb_busy), 1);
        chk("stuck_m_ready", 32'(m_ready), 0);
        e.onehot = 4'b0001;
        e.rdata  = '0;
        e.ack    = 1'b0;
        e.tout   = 1'b0;
        sb.push_back(e);
        m_busy = 1'b0;
        @(negedge clock);
        chk("stuck_release_rsp", 32'(rsp_valid), 1);
`endif
        repeat (3) @(negedge clock);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
